// File: rtl/match_controller.sv
// Match flow for two fighters: health, round timer, round wins, phases.
// Drives freeze/round_reset to player logic and HUD values to the renderer.
module match_controller #(
  parameter int HEALTH_DEPTH  = 8,
  parameter int MAX_HEALTH    = 100,
  parameter int HIT_DAMAGE    = 10,
  parameter int TIMER_DEPTH   = 13,
  parameter int ROUND_FRAMES  = 5400,
  parameter int INTRO_FRAMES  = 120,
  parameter int END_FRAMES    = 180,
  parameter int ROUNDS_TO_WIN = 2,
  parameter int WIN_DEPTH     = 2
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    frame_tick,
  input  logic                    start,
  input  logic                    p1_connects,
  input  logic                    p2_connects,
  output logic [HEALTH_DEPTH-1:0] p1_health,
  output logic [HEALTH_DEPTH-1:0] p2_health,
  output logic [TIMER_DEPTH-1:0]  round_timer,
  output logic [WIN_DEPTH-1:0]    p1_wins,
  output logic [WIN_DEPTH-1:0]    p2_wins,
  output logic [2:0]              phase,
  output logic                    freeze,
  output logic                    round_reset,
  output logic [1:0]              match_winner
);

  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_INTRO = 3'd1;
  localparam logic [2:0] PH_FIGHT = 3'd2;
  localparam logic [2:0] PH_END   = 3'd3;
  localparam logic [2:0] PH_MATCH = 3'd4;

  localparam int CNT_MAX =
    (INTRO_FRAMES > END_FRAMES) ? INTRO_FRAMES : END_FRAMES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INTRO_LAST =
    CNT_W'(INTRO_FRAMES - 1);
  localparam logic [CNT_W-1:0] END_LAST =
    CNT_W'(END_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [HEALTH_DEPTH-1:0] HP_FULL =
    HEALTH_DEPTH'(MAX_HEALTH);
  localparam logic [HEALTH_DEPTH-1:0] HP_HIT =
    HEALTH_DEPTH'(HIT_DAMAGE);
  localparam logic [TIMER_DEPTH-1:0] T_FULL =
    TIMER_DEPTH'(ROUND_FRAMES);
  localparam logic [TIMER_DEPTH-1:0] T_ONE =
    TIMER_DEPTH'(1);
  localparam logic [WIN_DEPTH-1:0] W_GOAL =
    WIN_DEPTH'(ROUNDS_TO_WIN);
  localparam logic [WIN_DEPTH-1:0] W_ONE = WIN_DEPTH'(1);
  localparam logic [WIN_DEPTH-1:0] W_MAX = '1;

  logic [2:0]              r_phase;
  logic [2:0]              w_phase_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [HEALTH_DEPTH-1:0] r_p1_hp;
  logic [HEALTH_DEPTH-1:0] r_p2_hp;
  logic [TIMER_DEPTH-1:0]  r_timer;
  logic [WIN_DEPTH-1:0]    r_p1_wins;
  logic [WIN_DEPTH-1:0]    r_p2_wins;
  logic [1:0]              r_winner;
  logic                    r_freeze;
  logic                    r_round_reset;
  logic                    r_start_q;
  logic                    r_p1c_q;
  logic                    r_p2c_q;

  logic w_start_edge;
  logic w_p1_hit;
  logic w_p2_hit;
  logic w_round_over;
  logic w_intro_done;
  logic w_end_done;
  logic w_match_won;

  logic w_enter_intro;
  logic w_enter_end;
  logic w_clear_wins;
  logic w_fight_live;
  logic w_award_p1;
  logic w_award_p2;
  logic w_set_winner;
  logic w_cnt_run;

  function automatic logic [HEALTH_DEPTH-1:0] f_dmg(
    input logic [HEALTH_DEPTH-1:0] hp
  );
    return (32'(hp) > HIT_DAMAGE) ? hp - HP_HIT : '0;
  endfunction

  assign w_start_edge = start & ~r_start_q;
  assign w_p1_hit     = p1_connects & ~r_p1c_q;
  assign w_p2_hit     = p2_connects & ~r_p2c_q;

  // End check looks at registered values, one cycle after the update
  assign w_round_over = (r_p1_hp == '0) | (r_p2_hp == '0) |
                        (r_timer == '0);
  assign w_intro_done = frame_tick & (r_cnt == INTRO_LAST);
  assign w_end_done   = frame_tick & (r_cnt == END_LAST);
  assign w_match_won  = (r_p1_wins == W_GOAL) |
                        (r_p2_wins == W_GOAL);

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_phase <= PH_IDLE;
    end else begin
      r_phase <= w_phase_nxt;
    end
  end

  always_comb begin
    w_phase_nxt = r_phase;
    unique case (r_phase)
      PH_IDLE:  if (w_start_edge) w_phase_nxt = PH_INTRO;
      PH_INTRO: if (w_intro_done) w_phase_nxt = PH_FIGHT;
      PH_FIGHT: if (w_round_over) w_phase_nxt = PH_END;
      PH_END:
        if (w_end_done)
          w_phase_nxt = w_match_won ? PH_MATCH : PH_INTRO;
      PH_MATCH: if (w_start_edge) w_phase_nxt = PH_INTRO;
      default:  w_phase_nxt = PH_IDLE;
    endcase
  end

  always_comb begin
    w_enter_intro = 1'b0;
    w_enter_end   = 1'b0;
    w_clear_wins  = 1'b0;
    w_fight_live  = 1'b0;
    w_award_p1    = 1'b0;
    w_award_p2    = 1'b0;
    w_set_winner  = 1'b0;
    w_cnt_run     = 1'b0;
    unique case (r_phase)
      PH_IDLE, PH_MATCH: begin
        w_clear_wins  = w_start_edge;
        w_enter_intro = w_start_edge;
      end
      PH_INTRO: w_cnt_run = frame_tick;
      PH_FIGHT: begin
        w_enter_end  = w_round_over;
        w_fight_live = ~w_round_over;
        w_award_p1   = w_round_over & (r_p1_hp > r_p2_hp);
        w_award_p2   = w_round_over & (r_p2_hp > r_p1_hp);
      end
      PH_END: begin
        w_cnt_run     = frame_tick;
        w_set_winner  = w_end_done & w_match_won;
        w_enter_intro = w_end_done & ~w_match_won;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_start_q     <= 1'b0;
      r_p1c_q       <= 1'b0;
      r_p2c_q       <= 1'b0;
      r_freeze      <= 1'b1;
      r_round_reset <= 1'b0;
    end else begin
      r_start_q     <= start;
      r_p1c_q       <= p1_connects;
      r_p2c_q       <= p2_connects;
      r_freeze      <= (w_phase_nxt != PH_FIGHT);
      r_round_reset <= w_enter_intro;
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_enter_intro | w_enter_end) begin
      r_cnt <= '0;
    end else if (w_cnt_run) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_p1_hp <= HP_FULL;
      r_p2_hp <= HP_FULL;
    end else if (w_enter_intro) begin
      r_p1_hp <= HP_FULL;
      r_p2_hp <= HP_FULL;
    end else if (w_fight_live) begin
      if (w_p2_hit) r_p1_hp <= f_dmg(r_p1_hp);
      if (w_p1_hit) r_p2_hp <= f_dmg(r_p2_hp);
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_timer <= T_FULL;
    end else if (w_enter_intro) begin
      r_timer <= T_FULL;
    end else if (w_fight_live & frame_tick & (r_timer != '0)) begin
      r_timer <= r_timer - T_ONE;
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_p1_wins <= '0;
      r_p2_wins <= '0;
    end else if (w_clear_wins) begin
      r_p1_wins <= '0;
      r_p2_wins <= '0;
    end else begin
      if (w_award_p1 & (r_p1_wins != W_MAX))
        r_p1_wins <= r_p1_wins + W_ONE;
      if (w_award_p2 & (r_p2_wins != W_MAX))
        r_p2_wins <= r_p2_wins + W_ONE;
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_winner <= 2'b00;
    end else if (w_clear_wins) begin
      r_winner <= 2'b00;
    end else if (w_set_winner) begin
      r_winner <= (r_p1_wins == W_GOAL) ? 2'b01 : 2'b10;
    end
  end

  assign p1_health    = r_p1_hp;
  assign p2_health    = r_p2_hp;
  assign round_timer  = r_timer;
  assign p1_wins      = r_p1_wins;
  assign p2_wins      = r_p2_wins;
  assign phase        = r_phase;
  assign freeze       = r_freeze;
  assign round_reset  = r_round_reset;
  assign match_winner = r_winner;

endmodule
